// File: rtl/decode_queue.sv
// In-order instruction queue between IFU and EXU; the head entry is decoded
// combinationally into register/CSR fields and an exception cause.
module decode_queue #(
    parameter int unsigned DEPTH  = 2,
    parameter bit          CSR_EN = 1'b1,
    parameter bit          BTB_EN = 1'b1
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [31:0]              i_inst,
    input  logic [31:0]              i_pc,
    input  logic [31:0]              i_imm,
    input  logic                     i_exception,
    input  logic [3:0]               i_mcause,
    input  logic                     i_predict,
    output logic                     o_valid,
    input  logic                     i_ready,
    input  logic                     i_stall,
    input  logic                     i_flush,
    output logic [6:0]               o_op,
    output logic [2:0]               o_func,
    output logic [4:0]               o_reg_rd,
    output logic [4:0]               o_reg_rs1,
    output logic [4:0]               o_reg_rs2,
    output logic                     o_reg_wen,
    output logic [31:0]              o_imm,
    output logic [31:0]              o_pc,
    output logic [11:0]              o_csr,
    output logic [1:0]               o_csr_t,
    output logic                     o_mret,
    output logic                     o_exception,
    output logic [3:0]               o_mcause,
    output logic                     o_predict,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic [31:0] inst_q   [DEPTH];
    logic [31:0] pc_q     [DEPTH];
    logic [31:0] imm_q    [DEPTH];
    logic        exc_q    [DEPTH];
    logic [3:0]  mcause_q [DEPTH];

    logic enq;
    logic deq;

    assign o_ready = (count != CNT_W'(DEPTH));
    assign o_valid = (count != '0);
    assign o_count = count;
    assign enq     = i_valid & o_ready & ~i_flush;
    assign deq     = o_valid & i_ready & ~i_stall & ~i_flush;

    // Pointer and occupancy bookkeeping; flush discards any same-cycle traffic.
    always_ff @(posedge i_clock) begin
        if (i_reset || i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
            if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
            if (enq && !deq)      count <= count + CNT_W'(1);
            else if (deq && !enq) count <= count - CNT_W'(1);
        end
    end

    // Payload storage is not reset; o_valid qualifies it.
    always_ff @(posedge i_clock) begin
        if (enq) begin
            inst_q[wr_ptr]   <= i_inst;
            pc_q[wr_ptr]     <= i_pc;
            imm_q[wr_ptr]    <= i_imm;
            exc_q[wr_ptr]    <= i_exception;
            mcause_q[wr_ptr] <= i_mcause;
        end
    end

    logic head_predict;

    if (BTB_EN) begin : g_btb
        logic pred_q [DEPTH];
        always_ff @(posedge i_clock) begin
            if (enq) pred_q[wr_ptr] <= i_predict;
        end
        assign head_predict = pred_q[rd_ptr];
    end else begin : g_no_btb
        assign head_predict = 1'b0;
    end

    logic [31:0] head_inst;
    logic        head_exc;
    logic [3:0]  head_mcause;

    assign head_inst   = inst_q[rd_ptr];
    assign head_exc    = exc_q[rd_ptr];
    assign head_mcause = mcause_q[rd_ptr];

    assign o_op      = head_inst[6:0];
    assign o_reg_rd  = head_inst[11:7];
    assign o_func    = head_inst[14:12];
    assign o_reg_rs1 = head_inst[19:15];
    assign o_reg_rs2 = head_inst[24:20];
    assign o_csr     = head_inst[31:20];
    assign o_imm     = imm_q[rd_ptr];
    assign o_pc      = pc_q[rd_ptr];
    assign o_predict = head_predict;

    logic legal;
    logic wen_class;
    logic is_system;

    // Opcode class decode on op[6:2].
    always_comb begin
        legal     = 1'b0;
        wen_class = 1'b0;
        is_system = 1'b0;
        case (head_inst[6:2])
            5'b00100, 5'b01100, 5'b00000, 5'b11011,
            5'b11001, 5'b00101, 5'b01101: begin
                legal     = 1'b1;
                wen_class = 1'b1;
            end
            5'b01000, 5'b11000, 5'b00011: legal = 1'b1;
            5'b11100: begin
                legal     = CSR_EN;
                is_system = CSR_EN;
            end
            default: ;
        endcase
    end

    logic is_ecall;
    logic is_ebreak;

    assign is_ecall  = is_system & (head_inst == INST_ECALL);
    assign is_ebreak = is_system & (head_inst == INST_EBREAK);
    assign o_mret    = (head_inst == INST_MRET);
    assign o_csr_t   = {o_mret, is_system & (o_func != 3'd0)};
    assign o_reg_wen = o_valid & wen_class & (o_reg_rd != 5'd0);

    logic exc_c;
    logic [3:0] mcause_c;

    // Cause priority: fetch fault > illegal > ebreak > ecall.
    always_comb begin
        exc_c    = 1'b1;
        mcause_c = head_mcause;
        if (!head_exc) begin
            if (!legal)         mcause_c = 4'd2;
            else if (is_ebreak) mcause_c = 4'd3;
            else if (is_ecall)  mcause_c = 4'd11;
            else begin
                exc_c    = 1'b0;
                mcause_c = 4'd0;
            end
        end
    end

    assign o_exception = o_valid & exc_c;
    assign o_mcause    = mcause_c;

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: ordering, fill/drain, stall, flush and
// head decode, with a CSR_EN=0 instance sharing the same stimulus.
module tb_decode_queue;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic        i_valid;
    logic [31:0] i_inst;
    logic [31:0] i_pc;
    logic [31:0] i_imm;
    logic        i_exception;
    logic [3:0]  i_mcause;
    logic        i_predict;
    logic        i_ready;
    logic        i_stall;
    logic        i_flush;

    logic        o_ready, o_valid, o_reg_wen, o_mret, o_exception, o_predict;
    logic [6:0]  o_op;
    logic [2:0]  o_func;
    logic [4:0]  o_reg_rd, o_reg_rs1, o_reg_rs2;
    logic [31:0] o_imm, o_pc;
    logic [11:0] o_csr;
    logic [1:0]  o_csr_t;
    logic [3:0]  o_mcause;
    logic [2:0]  o_count;

    logic        b_ready, b_valid, b_reg_wen, b_mret, b_exception, b_predict;
    logic [6:0]  b_op;
    logic [2:0]  b_func;
    logic [4:0]  b_reg_rd, b_reg_rs1, b_reg_rs2;
    logic [31:0] b_imm, b_pc;
    logic [11:0] b_csr;
    logic [1:0]  b_csr_t;
    logic [3:0]  b_mcause;
    logic [1:0]  b_count;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 i_clock = ~i_clock;

    decode_queue #(.DEPTH(4), .CSR_EN(1'b1), .BTB_EN(1'b1)) u_dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
        .i_inst(i_inst), .i_pc(i_pc), .i_imm(i_imm), .i_exception(i_exception),
        .i_mcause(i_mcause), .i_predict(i_predict), .o_valid(o_valid),
        .i_ready(i_ready), .i_stall(i_stall), .i_flush(i_flush),
        .o_op(o_op), .o_func(o_func), .o_reg_rd(o_reg_rd), .o_reg_rs1(o_reg_rs1),
        .o_reg_rs2(o_reg_rs2), .o_reg_wen(o_reg_wen), .o_imm(o_imm), .o_pc(o_pc),
        .o_csr(o_csr), .o_csr_t(o_csr_t), .o_mret(o_mret), .o_exception(o_exception),
        .o_mcause(o_mcause), .o_predict(o_predict), .o_count(o_count)
    );

    decode_queue #(.DEPTH(2), .CSR_EN(1'b0), .BTB_EN(1'b1)) u_dut_nocsr (
        .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .o_ready(b_ready),
        .i_inst(i_inst), .i_pc(i_pc), .i_imm(i_imm), .i_exception(i_exception),
        .i_mcause(i_mcause), .i_predict(i_predict), .o_valid(b_valid),
        .i_ready(i_ready), .i_stall(i_stall), .i_flush(i_flush),
        .o_op(b_op), .o_func(b_func), .o_reg_rd(b_reg_rd), .o_reg_rs1(b_reg_rs1),
        .o_reg_rs2(b_reg_rs2), .o_reg_wen(b_reg_wen), .o_imm(b_imm), .o_pc(b_pc),
        .o_csr(b_csr), .o_csr_t(b_csr_t), .o_mret(b_mret), .o_exception(b_exception),
        .o_mcause(b_mcause), .o_predict(b_predict), .o_count(b_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge i_clock);
        #1;
    endtask

    task automatic set_entry(input logic [31:0] inst, input logic [31:0] pc,
                             input logic exc, input logic [3:0] mcause, input logic pred);
        i_inst      = inst;
        i_pc        = pc;
        i_imm       = 32'hA5A5_0000 | pc[15:0];
        i_exception = exc;
        i_mcause    = mcause;
        i_predict   = pred;
    endtask

    // Enqueue one entry into an empty queue and leave it at the head.
    task automatic load(input logic [31:0] inst, input logic exc, input logic [3:0] mcause,
                        input logic pred);
        set_entry(inst, 32'h0000_4000, exc, mcause, pred);
        i_ready = 1'b0;
        i_valid = 1'b1;
        step();
        i_valid = 1'b0;
    endtask

    task automatic drop();
        i_ready = 1'b1;
        step();
        i_ready = 1'b0;
    endtask

    initial begin
        i_reset = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_stall = 1'b0;
        i_flush = 1'b0;
        set_entry(32'h0, 32'h0, 1'b0, 4'd0, 1'b0);
        step();
        step();
        i_reset = 1'b0;

        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_count", 32'(o_count), 32'd0);
        check("rst_exc",   32'(o_exception), 32'd0);

        // Back-to-back addi with downstream always ready.
        i_ready = 1'b1;
        i_valid = 1'b1;
        set_entry(32'h0050_0093, 32'h8000_0000, 1'b0, 4'd0, 1'b0);
        check("b2b_pre_valid", 32'(o_valid), 32'd0);
        step();
        check("b2b0_valid", 32'(o_valid), 32'd1);
        check("b2b0_pc",    o_pc, 32'h8000_0000);
        check("b2b0_imm",   o_imm, 32'hA5A5_0000);
        check("b2b0_op",    32'(o_op), 32'h13);
        check("b2b0_rd",    32'(o_reg_rd), 32'd1);
        check("b2b0_wen",   32'(o_reg_wen), 32'd1);
        set_entry(32'h00A0_0113, 32'h8000_0004, 1'b0, 4'd0, 1'b0);
        step();
        check("b2b1_pc",    o_pc, 32'h8000_0004);
        check("b2b1_rd",    32'(o_reg_rd), 32'd2);
        check("b2b1_count", 32'(o_count), 32'd1);
        set_entry(32'h00F0_0193, 32'h8000_0008, 1'b0, 4'd0, 1'b0);
        step();
        check("b2b2_pc",    o_pc, 32'h8000_0008);
        check("b2b2_rd",    32'(o_reg_rd), 32'd3);
        i_valid = 1'b0;
        step();
        check("b2b_empty_valid", 32'(o_valid), 32'd0);
        check("b2b_empty_count", 32'(o_count), 32'd0);

        // Fill DEPTH=4 with downstream blocked; offer 6 entries.
        i_ready = 1'b0;
        i_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            set_entry(32'h13 | (32'(k + 1) << 7), 32'h1000 + 32'(4 * k), 1'b0, 4'd0, 1'b0);
            check($sformatf("fill%0d_ready", k), 32'(o_ready), (k < 4) ? 32'd1 : 32'd0);
            step();
        end
        i_valid = 1'b0;
        check("full_count", 32'(o_count), 32'd4);
        check("full_ready", 32'(o_ready), 32'd0);
        i_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k == 0) check("full_deq_ready", 32'(o_ready), 32'd0);
            check($sformatf("drain%0d_pc", k), o_pc, 32'h1000 + 32'(4 * k));
            check($sformatf("drain%0d_rd", k), 32'(o_reg_rd), 32'(k + 1));
            step();
        end
        check("drain_count", 32'(o_count), 32'd0);
        check("drain_valid", 32'(o_valid), 32'd0);

        // Stall at a full queue holds the head.
        i_ready = 1'b0;
        i_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_entry(32'h0000_0013, 32'h2000 + 32'(4 * k), 1'b0, 4'd0, 1'b0);
            step();
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("stall%0d_count", k), 32'(o_count), 32'd4);
            check($sformatf("stall%0d_pc", k), o_pc, 32'h2000);
        end
        i_stall = 1'b0;
        step();
        check("unstall_count", 32'(o_count), 32'd3);
        check("unstall_pc", o_pc, 32'h2004);

        // Flush with three entries and a concurrent offer.
        i_flush = 1'b1;
        i_valid = 1'b1;
        set_entry(32'h0050_0093, 32'h3000, 1'b0, 4'd0, 1'b0);
        step();
        i_flush = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        check("flush_count", 32'(o_count), 32'd0);
        check("flush_valid", 32'(o_valid), 32'd0);
        check("flush_ready", 32'(o_ready), 32'd1);
        step();
        check("flush_nostore", 32'(o_count), 32'd0);

        // Head decode and exception priority.
        load(32'h0000_0073, 1'b0, 4'd0, 1'b0);
        check("ecall_exc",    32'(o_exception), 32'd1);
        check("ecall_cause",  32'(o_mcause), 32'd11);
        check("ecall_nocsr",  32'(b_mcause), 32'd2);
        drop();
        check("empty_exc",    32'(o_exception), 32'd0);
        load(32'h0010_0073, 1'b0, 4'd0, 1'b0);
        check("ebreak_cause", 32'(o_mcause), 32'd3);
        drop();
        load(32'hFFFF_FFFF, 1'b0, 4'd0, 1'b0);
        check("illegal_exc",   32'(o_exception), 32'd1);
        check("illegal_cause", 32'(o_mcause), 32'd2);
        drop();
        load(32'hFFFF_FFFF, 1'b1, 4'd1, 1'b0);
        check("fetch_cause",   32'(o_mcause), 32'd1);
        drop();
        load(32'h3020_0073, 1'b0, 4'd0, 1'b1);
        check("mret_flag",   32'(o_mret), 32'd1);
        check("mret_csr_t",  32'(o_csr_t), 32'd2);
        check("mret_exc",    32'(o_exception), 32'd0);
        check("mret_pred",   32'(o_predict), 32'd1);
        check("mret_nocsr_exc",   32'(b_exception), 32'd1);
        check("mret_nocsr_cause", 32'(b_mcause), 32'd2);
        drop();
        load(32'h3052_9073, 1'b0, 4'd0, 1'b0);
        check("csrrw_csr",   32'(o_csr), 32'h305);
        check("csrrw_csr_t", 32'(o_csr_t), 32'd1);
        check("csrrw_exc",   32'(o_exception), 32'd0);
        check("csrrw_pred",  32'(o_predict), 32'd0);
        check("csrrw_nocsr_exc",   32'(b_exception), 32'd1);
        check("csrrw_nocsr_cause", 32'(b_mcause), 32'd2);
        drop();
        load(32'h0020_8033, 1'b0, 4'd0, 1'b0);
        check("add_x0_op",  32'(o_op), 32'h33);
        check("add_x0_rs2", 32'(o_reg_rs2), 32'd2);
        check("add_x0_wen", 32'(o_reg_wen), 32'd0);
        check("add_x0_exc", 32'(o_exception), 32'd0);
        drop();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
